// File: rtl/contador_pkg.sv
// Purpose: shared defaults, direction constants and parameter-range helpers for contador_nbits.
// Latency: none (package only).
// Backpressure: none (package only).
// Build option: CONTADOR_SAT_EN (used by contador_nbits) selects saturating instead of wrapping steps.
package contador_pkg;

    localparam int              DEF_WIDTH    = 8;
    localparam longint unsigned DEF_MODULO   = 64'd256;
    localparam int              DEF_PRESCALE = 1;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Ceiling log2; clog2(0) = clog2(1) = 0.
    function automatic int clog2(input longint unsigned v);
        int r;
        r = 0;
        for (int i = 0; i < 63; i++) begin
            if ((64'd1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Legal count range: 2 .. 2**width, width 1..32.
    function automatic bit modulo_ok(input int width, input longint unsigned modulo);
        return (width >= 1) && (width <= 32) &&
               (modulo >= 64'd2) && (modulo <= (64'd1 << width));
    endfunction

endpackage

// File: rtl/contador_prescaler.sv
// Purpose: divides enabled cycles by PRESCALE, producing a one-cycle step on the last one.
// Latency: step is combinational from the registered phase and enable.
// Backpressure: none; enable=0 freezes the phase, clear restarts it.
// Ports: clk, reset (sync, active-low), enable, clear (restart phase), step (out).
module contador_prescaler
    import contador_pkg::*;
#(
    parameter int PRESCALE = DEF_PRESCALE
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic step
);

    if ((PRESCALE < 1) || (PRESCALE > 65535)) begin : g_bad_prescale
        $error("contador_prescaler: PRESCALE out of range 1..65535");
    end

    // At least one bit so PRESCALE=1 still elaborates; the phase then stays at 0
    // and step reduces to enable.
    localparam int PW = (clog2(longint'(PRESCALE)) < 1) ? 1 : clog2(longint'(PRESCALE));
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_cnt;

    assign step = enable && (pre_cnt == LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            pre_cnt <= '0;
        end else if (clear) begin
            pre_cnt <= '0;
        end else if (enable) begin
            pre_cnt <= step ? '0 : pre_cnt + PW'(1);
        end
    end

endmodule

// File: rtl/contador_nbits.sv
// Purpose: up/down modulo-MODULO counter with prescaler, clamped parallel load, tc flag and wrap pulse.
// Latency: count/wrap update one edge after the step or load; tc is combinational from count and up.
// Backpressure: none; enable=0 holds count and prescaler phase, load overrides enable.
// Ports: clk, reset (sync, active-low), enable, up, load, load_value[WIDTH] in; count[WIDTH], tc, wrap out.
// Build option: define CONTADOR_SAT_EN for saturating mode (step at tc holds count, wrap still pulses).
module contador_nbits
    import contador_pkg::*;
#(
    parameter int              WIDTH    = DEF_WIDTH,
    parameter longint unsigned MODULO   = 64'd1 << WIDTH,
    parameter int              PRESCALE = DEF_PRESCALE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);

    if (!modulo_ok(WIDTH, MODULO)) begin : g_bad_modulo
        $error("contador_nbits: WIDTH/MODULO out of range");
    end

    // One extra bit so MODULO itself is representable when MODULO = 2**WIDTH.
    localparam int           CW      = WIDTH + 1;
    localparam logic [CW-1:0] MOD_EXT = CW'(MODULO);
    localparam logic [CW-1:0] MOD_M1  = CW'(MODULO - 64'd1);
    localparam logic [WIDTH-1:0] MAX_CNT = MOD_M1[WIDTH-1:0];

    logic             step;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] count_next;

    contador_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .clear  (load),
        .step   (step)
    );

    assign load_clamped = ({1'b0, load_value} >= MOD_EXT) ? MAX_CNT : load_value;

    assign tc = (up == DIR_UP) ? ({1'b0, count} == MOD_M1) : (count == '0);

    always_comb begin
        count_next = count;
        if (up == DIR_UP) begin
            if (tc) begin
`ifdef CONTADOR_SAT_EN
                count_next = count;
`else
                count_next = '0;
`endif
            end else begin
                count_next = count + WIDTH'(1);
            end
        end else begin
            if (tc) begin
`ifdef CONTADOR_SAT_EN
                count_next = count;
`else
                count_next = MAX_CNT;
`endif
            end else begin
                count_next = count - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
            wrap  <= 1'b0;
        end else if (load) begin
            count <= load_clamped;
            wrap  <= 1'b0;
        end else if (step) begin
            count <= count_next;
            wrap  <= tc;
        end else begin
            wrap  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_contador_nbits.sv
// Purpose: randomized self-checking bench for contador_nbits across three parameter sets.
// Latency: outputs compared each cycle against a behavioural model advanced at every clock edge.
// Backpressure: not applicable.
module tb_contador_nbits;
    import contador_pkg::*;

    localparam int NDUT = 3;
    localparam int MODS [NDUT] = '{256, 10, 100};
    localparam int PRES [NDUT] = '{1, 4, 3};

`ifdef CONTADOR_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       enable;
    logic       up;
    logic       load;
    logic [7:0] load_value;
    logic [7:0] cnt  [NDUT];
    logic       tcs  [NDUT];
    logic       wrps [NDUT];

    int m_cnt [NDUT];
    int m_pre [NDUT];
    int m_wrp [NDUT];

    int n_chk;
    int n_pass;
    int cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    contador_nbits #(.WIDTH(8), .MODULO(64'd256), .PRESCALE(1)) u_d0 (
        .clk(clk), .reset(reset), .enable(enable), .up(up), .load(load),
        .load_value(load_value), .count(cnt[0]), .tc(tcs[0]), .wrap(wrps[0]));

    contador_nbits #(.WIDTH(8), .MODULO(64'd10), .PRESCALE(4)) u_d1 (
        .clk(clk), .reset(reset), .enable(enable), .up(up), .load(load),
        .load_value(load_value), .count(cnt[1]), .tc(tcs[1]), .wrap(wrps[1]));

    contador_nbits #(.WIDTH(8), .MODULO(64'd100), .PRESCALE(3)) u_d2 (
        .clk(clk), .reset(reset), .enable(enable), .up(up), .load(load),
        .load_value(load_value), .count(cnt[2]), .tc(tcs[2]), .wrap(wrps[2]));

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    // Behavioural reference: applies one clock edge using the current inputs.
    task automatic model_edge();
        for (int i = 0; i < NDUT; i++) begin
            int  m;
            bit  at_end;
            m = MODS[i];
            if (!reset) begin
                m_cnt[i] = 0;
                m_pre[i] = 0;
                m_wrp[i] = 0;
            end else if (load) begin
                m_cnt[i] = (int'(load_value) >= m) ? m - 1 : int'(load_value);
                m_pre[i] = 0;
                m_wrp[i] = 0;
            end else if (enable) begin
                if (m_pre[i] == PRES[i] - 1) begin
                    m_pre[i] = 0;
                    at_end   = up ? (m_cnt[i] == m - 1) : (m_cnt[i] == 0);
                    m_wrp[i] = at_end ? 1 : 0;
                    if (!(SAT && at_end)) begin
                        m_cnt[i] = up ? (m_cnt[i] + 1) % m : (m_cnt[i] + m - 1) % m;
                    end
                end else begin
                    m_pre[i] = m_pre[i] + 1;
                    m_wrp[i] = 0;
                end
            end else begin
                m_wrp[i] = 0;
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NDUT; i++) begin
            int exp_tc;
            exp_tc = up ? int'(m_cnt[i] == MODS[i] - 1) : int'(m_cnt[i] == 0);
            chk($sformatf("d%0d.count", i), int'(cnt[i]), m_cnt[i]);
            chk($sformatf("d%0d.tc", i),    int'(tcs[i]), exp_tc);
            chk($sformatf("d%0d.wrap", i),  int'(wrps[i]), m_wrp[i]);
        end
    endtask

    // Drive inputs away from the active edge, compare, then let the edge happen.
    task automatic tick(input bit r, input bit e, input bit u, input bit l, input logic [7:0] v);
        @(negedge clk);
        reset      = r;
        enable     = e;
        up         = u;
        load       = l;
        load_value = v;
        #1;
        check_all();
        @(posedge clk);
        model_edge();
        cyc++;
    endtask

    initial begin
        logic rb, eb, ub, lb;
        n_chk  = 0;
        n_pass = 0;
        cyc    = 0;
        for (int i = 0; i < NDUT; i++) begin
            m_cnt[i] = 0;
            m_pre[i] = 0;
            m_wrp[i] = 0;
        end
        reset      = 1'b0;
        enable     = 1'b0;
        up         = DIR_UP;
        load       = 1'b0;
        load_value = 8'd0;
        @(posedge clk);
        model_edge();

        // Reset state, then a full up run past the 255 -> 0 rollover.
        tick(1'b0, 1'b0, DIR_UP, 1'b0, 8'd0);
        for (int k = 0; k < 262; k++) tick(1'b1, 1'b1, DIR_UP, 1'b0, 8'd0);

        // Down count from reset, with enable gaps mid-prescale.
        tick(1'b0, 1'b1, DIR_DOWN, 1'b0, 8'd0);
        for (int k = 0; k < 30; k++) tick(1'b1, 1'b1, DIR_DOWN, 1'b0, 8'd0);
        tick(1'b1, 1'b1, DIR_DOWN, 1'b0, 8'd0);
        for (int k = 0; k < 3; k++) tick(1'b1, 1'b0, DIR_DOWN, 1'b0, 8'd0);
        for (int k = 0; k < 12; k++) tick(1'b1, 1'b1, DIR_DOWN, 1'b0, 8'd0);

        // Clamped load, then loads colliding with step conditions.
        tick(1'b1, 1'b0, DIR_UP, 1'b1, 8'd200);
        for (int k = 0; k < 5; k++) tick(1'b1, 1'b1, DIR_UP, 1'b0, 8'd0);
        for (int k = 0; k < 8; k++) begin
            tick(1'b1, 1'b1, DIR_UP, 1'b1, 8'd5);
            tick(1'b1, 1'b1, DIR_UP, 1'b0, 8'd0);
            tick(1'b1, 1'b1, DIR_UP, 1'b1, 8'd255);
        end

        // Near the top for the default instance: 254 -> 255 -> tc handling.
        tick(1'b1, 1'b1, DIR_UP, 1'b1, 8'd254);
        for (int k = 0; k < 6; k++) tick(1'b1, 1'b1, DIR_UP, 1'b0, 8'd0);
        tick(1'b0, 1'b1, DIR_UP, 1'b0, 8'd0);
        tick(1'b1, 1'b1, DIR_DOWN, 1'b0, 8'd0);

        // Randomized mix of reset, load, enable and direction changes.
        ub = DIR_UP;
        for (int k = 0; k < 1500; k++) begin
            rb = ($urandom_range(63) != 0);
            lb = ($urandom_range(15) == 0);
            eb = ($urandom_range(3) != 0);
            if ($urandom_range(31) == 0) ub = ~ub;
            tick(rb, eb, ub, lb, 8'($urandom_range(255)));
        end

        @(negedge clk);
        #1;
        check_all();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
